// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the buffer write-port arbiter.
// The default depth and data width also size the buffer instance that sits behind it.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_DEPTH     = 64;
    localparam int DEF_DAT_WIDTH = 32;

    // Ceiling log2, used to size owner/pointer indices and the burst counter
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first set request at or after the start index,
// wrapping around, so every requester is eventually seen.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down to the start, so the nearest request wins last
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(start) + k) % N_REQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single buffer write port among N_REQ producers.
// Grants are combinational, bursts are bounded, and a local credit count keeps the
// lagging Full flag from letting the buffer overflow.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DAT_WIDTH = DEF_DAT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = 7,
    parameter int MAX_BURST = 4
) (
    input  logic                       Wrclk,
    input  logic                       Rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*DAT_WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]           gnt_o,
    input  logic                       fifo_full_i,
    input  logic                       rd_done_i,
    output logic                       fifo_wren_o,
    output logic [DAT_WIDTH-1:0]       fifo_din_o,
    output logic [CNT_W-1:0]           credit_o,
    output logic                       busy_o
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int BC_W  = clog2(MAX_BURST + 1);

    arb_state_e       state, state_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [BC_W-1:0]  burst_cnt, burst_cnt_n;
    logic [CNT_W-1:0] credit_n;

    logic             can_grant;
    logic             keep_owner;
    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] pick_start;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_winner;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             xfer;
    logic [DAT_WIDTH-1:0] sel_data;

    assign can_grant  = (credit_o != '0) && !fifo_full_i;
    assign owner_inc  = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign keep_owner = (state == BURST) && req_i[owner] && (burst_cnt < BC_W'(MAX_BURST));
    assign pick_start = (state == BURST) ? owner_inc : rr_ptr;
    assign busy_o     = (state == BURST);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_i),
        .start  (pick_start),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Choose who would be granted: the current owner while its burst lasts, else the RR winner
    always_comb begin
        grant_valid = keep_owner || pick_valid;
        grant_idx   = keep_owner ? owner : pick_winner;
    end

    // One-hot grant, suppressed while in reset or when the buffer cannot accept a word
    always_comb begin
        gnt_o = '0;
        if (!Rst && can_grant && grant_valid) begin
            gnt_o[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(gnt_o & req_i);

    // Route the granted requester's word toward the write data register
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data = data_i[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    // Next arbitration state; everything holds when no grant is possible
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        if (can_grant) begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state_n     = BURST;
                        owner_n     = pick_winner;
                        burst_cnt_n = BC_W'(1);
                    end
                end
                BURST: begin
                    if (keep_owner) begin
                        burst_cnt_n = burst_cnt + BC_W'(1);
                    end else if (pick_valid) begin
                        owner_n     = pick_winner;
                        burst_cnt_n = BC_W'(1);
                        rr_ptr_n    = (pick_winner == IDX_W'(N_REQ - 1)) ? '0 : pick_winner + IDX_W'(1);
                    end else begin
                        state_n  = IDLE;
                        rr_ptr_n = owner_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Credit falls on a transfer, rises on a read, and saturates at the buffer depth
    always_comb begin
        credit_n = credit_o;
        if (xfer && !rd_done_i) begin
            credit_n = credit_o - CNT_W'(1);
        end else if (!xfer && rd_done_i && (credit_o != CNT_W'(DEPTH))) begin
            credit_n = credit_o + CNT_W'(1);
        end
    end

    // Arbitration and credit registers
    always_ff @(posedge Wrclk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            credit_o  <= CNT_W'(DEPTH);
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
            credit_o  <= credit_n;
        end
    end

    // Registered write port; data holds its last value between transfers
    always_ff @(posedge Wrclk or posedge Rst) begin
        if (Rst) begin
            fifo_wren_o <= 1'b0;
            fifo_din_o  <= '0;
        end else begin
            fifo_wren_o <= xfer;
            if (xfer) begin
                fifo_din_o <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic, with a
// behavioural model predicting grants/credit and a scoreboard for the write port.
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DAT_WIDTH = 32;
    localparam int DEPTH     = 64;
    localparam int CNT_W     = 7;
    localparam int MAX_BURST = 4;

    logic                       Wrclk = 1'b0;
    logic                       Rst;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*DAT_WIDTH-1:0] data;
    logic [N_REQ-1:0]           gnt;
    logic                       full;
    logic                       rd_done;
    logic                       wren;
    logic [DAT_WIDTH-1:0]       din;
    logic [CNT_W-1:0]           credit;
    logic                       busy;

    int checks = 0;
    int passes = 0;
    logic [DAT_WIDTH-1:0] exp_q[$];
    logic [DAT_WIDTH-1:0] mon_exp;
    bit model_live = 1'b0;

    int m_busy, m_owner, m_cnt, m_ptr, m_credit;
    int last_grant = -1;
    int xfer_total = 0;
    int base;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .Wrclk       (Wrclk),
        .Rst         (Rst),
        .req_i       (req),
        .data_i      (data),
        .gnt_o       (gnt),
        .fifo_full_i (full),
        .rd_done_i   (rd_done),
        .fifo_wren_o (wren),
        .fifo_din_o  (din),
        .credit_o    (credit),
        .busy_o      (busy)
    );

    // Free-running write clock
    always #5 Wrclk = ~Wrclk;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every registered write must match the oldest word the model expects
    always @(negedge Wrclk) begin
        if (model_live && wren) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_wren", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("fifo_din", din, mon_exp);
            end
        end
    end

    function automatic int rr_first(input logic [N_REQ-1:0] r, input int start);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(start + k) % N_REQ]) return (start + k) % N_REQ;
        end
        return -1;
    endfunction

    // One clock: predict the grant from the arbitration rules, compare, then advance the model
    task automatic step();
        int w, n_busy, n_owner, n_cnt, n_ptr;
        logic [N_REQ-1:0] exp_gnt;
        @(negedge Wrclk);
        w = -1;
        n_busy = m_busy; n_owner = m_owner; n_cnt = m_cnt; n_ptr = m_ptr;
        if (m_credit != 0 && !full) begin
            if (m_busy != 0 && req[m_owner] && m_cnt < MAX_BURST) begin
                w = m_owner;
                n_cnt = m_cnt + 1;
            end else begin
                w = rr_first(req, (m_busy != 0) ? (m_owner + 1) % N_REQ : m_ptr);
                if (w >= 0) begin
                    n_busy = 1; n_owner = w; n_cnt = 1;
                    if (m_busy != 0) n_ptr = (w + 1) % N_REQ;
                end else if (m_busy != 0) begin
                    n_busy = 0;
                    n_ptr = (m_owner + 1) % N_REQ;
                end
            end
        end
        exp_gnt = (w >= 0) ? (N_REQ'(1) << w) : '0;
        check_output("gnt", gnt, exp_gnt);
        check_output("credit", credit, m_credit);
        check_output("busy", busy, m_busy);
        if (w >= 0) begin
            exp_q.push_back(data[w*DAT_WIDTH +: DAT_WIDTH]);
            xfer_total++;
        end
        @(posedge Wrclk);
        m_busy = n_busy; m_owner = n_owner; m_cnt = n_cnt; m_ptr = n_ptr;
        m_credit = m_credit - ((w >= 0) ? 1 : 0) + (rd_done ? 1 : 0);
        if (m_credit > DEPTH) m_credit = DEPTH;
        last_grant = w;
        #1;
    endtask

    // Assert reset away from the clock edge, check the reset values at once, release after an edge
    task automatic do_reset();
        model_live = 1'b0;
        Rst = 1'b1;
        #1;
        check_output("rst_gnt", gnt, 0);
        check_output("rst_credit", credit, DEPTH);
        check_output("rst_wren", wren, 0);
        check_output("rst_din", din, 0);
        check_output("rst_busy", busy, 0);
        exp_q.delete();
        @(posedge Wrclk);
        #1;
        Rst = 1'b0;
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_credit = DEPTH;
        last_grant = -1;
        model_live = 1'b1;
    endtask

    // Give the requester that just transferred a fresh word
    task automatic refresh_granted();
        if (last_grant >= 0) data[last_grant*DAT_WIDTH +: DAT_WIDTH] = $urandom;
    endtask

    // Random producers that hold requests until granted, occasionally withdrawing
    task automatic apply_stimulus(input int rd_pct, input int full_pct);
        for (int i = 0; i < N_REQ; i++) begin
            if (i == last_grant) begin
                req[i] = ($urandom_range(0, 3) != 0);
                data[i*DAT_WIDTH +: DAT_WIDTH] = $urandom;
            end else if (!req[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    data[i*DAT_WIDTH +: DAT_WIDTH] = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                req[i] = 1'b0;
            end
        end
        full    = ($urandom_range(0, 99) < full_pct);
        rd_done = ($urandom_range(0, 99) < rd_pct);
    endtask

    initial begin
        req = '1; data = '0; full = 1'b0; rd_done = 1'b0;
        do_reset();
        req = '0;

        // Single requester: bursts restart back to back
        for (int k = 0; k < 6; k++) begin
            req = 4'b0001;
            data[0 +: DAT_WIDTH] = DAT_WIDTH'(32'hA0 + k);
            step();
        end
        req = '0;
        step();
        step();
        check_output("credit_after_six", credit, 58);

        // All requesters: four grants each in rotation
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            refresh_granted();
            step();
        end

        // Credit exhaustion with no reads
        req = '0;
        do_reset();
        req = 4'b0100;
        base = xfer_total;
        for (int k = 0; k < 70; k++) begin
            refresh_granted();
            step();
        end
        check_output("transfers_to_empty", xfer_total - base, 64);
        check_output("credit_exhausted", credit, 0);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        refresh_granted();
        step();
        refresh_granted();
        step();
        check_output("one_more_transfer", xfer_total - base, 65);
        check_output("credit_zero_again", credit, 0);

        // Simultaneous transfer and read, then saturation at depth
        req = '0;
        rd_done = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check_output("credit_ten", credit, 10);
        req = 4'b0100;
        refresh_granted();
        step();
        check_output("credit_unchanged", credit, 10);
        req = '0;
        for (int k = 0; k < 60; k++) step();
        check_output("credit_saturated", credit, DEPTH);
        rd_done = 1'b0;

        // Full stall mid-burst with credit at 20, then resume
        req = 4'b1111;
        for (int k = 0; k < 44; k++) begin
            refresh_granted();
            step();
        end
        check_output("credit_twenty", credit, 20);
        full = 1'b1;
        for (int k = 0; k < 3; k++) step();
        full = 1'b0;
        for (int k = 0; k < 6; k++) begin
            refresh_granted();
            step();
        end

        // Randomized traffic, including a reset in the middle of activity
        for (int k = 0; k < 600; k++) begin
            apply_stimulus(20, 10);
            step();
        end
        for (int k = 0; k < 600; k++) begin
            apply_stimulus(70, 10);
            step();
            if (k == 300) do_reset();
        end
        for (int k = 0; k < 600; k++) begin
            apply_stimulus(45, 25);
            step();
        end

        req = '0; full = 1'b0; rd_done = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
